// File: rtl/fp_norm_sequencer_if.sv
// Operand/result handshake bundle for the normalization sequencer.
// The master side drives operands and accepts results; the slave side is the sequencer.
interface fp_norm_sequencer_if #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_underflow;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_underflow
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_underflow
    );
endinterface

// File: rtl/fp_norm_sequencer.sv
// Multi-cycle mantissa normalizer: one shared 16-bit priority encoder scans chunks
// MSB-first, then a single shift stage normalizes with zero/underflow handling.
module PriorityEncoder (
    input  logic [15:0] datain,
    output logic [3:0]  dataout,
    output logic        zero
);
    always_comb begin
        dataout = '0;
        for (int i = 0; i < 16; i++)
            if (datain[i]) dataout = 4'(i);
    end
    assign zero = ~|datain;
endmodule

module fp_norm_sequencer #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_norm_sequencer_if.slave  bus
);
    localparam int CHUNKS = MANT_W / 16;
    localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PW     = KW + 4;
    localparam int CW     = ((EXP_W > PW) ? EXP_W : PW) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [MANT_W-1:0] r_mant, r_out_mant;
    logic [EXP_W-1:0]  r_exp, r_out_exp;
    logic [KW-1:0]     r_k;
    logic [PW-1:0]     r_pos;
    logic              r_out_zero, r_out_uf;

    logic [15:0]       w_enc_in;
    logic [3:0]        w_enc_out;
    logic              w_enc_zero;
    logic [CW-1:0]     w_s, w_exp_ext;
    logic              w_fits;

    // Encoder sees zero outside SCAN so it never toggles on stale mantissa bits.
    assign w_enc_in = (r_state == S_SCAN) ? r_mant[{r_k, 4'b0000} +: 16] : 16'h0000;

    PriorityEncoder u_penc (
        .datain  (w_enc_in),
        .dataout (w_enc_out),
        .zero    (w_enc_zero)
    );

    assign w_s       = CW'(MANT_W - 1) - CW'(r_pos);
    assign w_exp_ext = CW'(r_exp);
    assign w_fits    = (w_exp_ext >= w_s);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_SCAN;
            S_SCAN:  if (!w_enc_zero) w_next = S_SHIFT;
                     else if (r_k == '0) w_next = S_DONE;
            S_SHIFT: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mant     <= '0;
            r_exp      <= '0;
            r_k        <= KW'(CHUNKS - 1);
            r_pos      <= '0;
            r_out_mant <= '0;
            r_out_exp  <= '0;
            r_out_zero <= 1'b0;
            r_out_uf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_mant <= bus.in_mant;
                    r_exp  <= bus.in_exp;
                    r_k    <= KW'(CHUNKS - 1);
                end
                S_SCAN: begin
                    if (!w_enc_zero) begin
                        r_pos <= {r_k, w_enc_out};
                    end else if (r_k != '0) begin
                        r_k <= r_k - KW'(1);
                    end else begin
                        r_out_mant <= '0;
                        r_out_exp  <= '0;
                        r_out_zero <= 1'b1;
                        r_out_uf   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // Short exponent caps the shift; result is left partially normalized.
                    if (w_fits) begin
                        r_out_mant <= r_mant << w_s;
                        r_out_exp  <= r_exp - EXP_W'(w_s);
                        r_out_uf   <= 1'b0;
                    end else begin
                        r_out_mant <= r_mant << r_exp;
                        r_out_exp  <= '0;
                        r_out_uf   <= 1'b1;
                    end
                    r_out_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = (r_state == S_IDLE);
    assign bus.out_valid     = (r_state == S_DONE);
    assign bus.out_mant      = r_out_mant;
    assign bus.out_exp       = r_out_exp;
    assign bus.out_zero      = r_out_zero;
    assign bus.out_underflow = r_out_uf;
endmodule
